gnr_node_lanes: RTL and testbench
=================================

GNR_NODE_LANES -- requirements
Module: gnr_node_lanes

Interface
REQ-001 Parameter N_IN, default 4, number of regulator inputs per lane (1..16).
REQ-002 Parameter N_LANE, default 2, number of independent state lanes (1..8).
REQ-003 Parameter DIV_W, default 4, width of the per-lane update-period field.
REQ-004 Parameter SW, default 4, width of the per-lane stability counter.
REQ-005 Parameter STEADY_LIM, default 8, stability count at which a lane reports steady (1..2^SW-1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 reset_nos  in  1  synchronous network re-initialise; loads init_state into all lanes.
REQ-009 init_state  in  N_LANE  per-lane value loaded on reset_nos.
REQ-010 start_lane  in  N_LANE  per-lane evaluation strobe, one bit per lane.
REQ-011 reg_in  in  N_IN*N_LANE  regulator states; lane k uses bits [k*N_IN +: N_IN].
REQ-012 act_mask  in  N_IN  selects activator inputs; shared by all lanes.
REQ-013 inh_mask  in  N_IN  selects inhibitor inputs; shared by all lanes.
REQ-014 func_sel  in  2  update function: 0 OR, 1 AND, 2 THRESH, 3 OR_INH.
REQ-015 thr  in  clog2(N_IN+1)  activator count threshold for THRESH.
REQ-016 period  in  DIV_W*N_LANE  per-lane skip count; lane k uses bits [k*DIV_W +: DIV_W].
REQ-017 s  out  N_LANE  registered node state per lane.
REQ-018 changed  out  N_LANE  one-cycle pulse when a lane's evaluation changes its state.
REQ-019 steady  out  N_LANE  high while the lane's stability count is >= STEADY_LIM.

Function
REQ-020 Per lane, a = reg_in_lane & act_mask and h = reg_in_lane & inh_mask.
REQ-021 OR: next = |a.
REQ-022 AND: next = &(a | ~act_mask); when act_mask == 0, next SHALL be 0.
REQ-023 THRESH: next = (popcount(a) >= thr); thr == 0 SHALL give 1; thr > N_IN SHALL give 0.
REQ-024 OR_INH: next = (|a) & ~(|h).
REQ-025 Each lane SHALL hold a down-counter cnt[DIV_W].
REQ-026 start_lane[k] with cnt == 0 is an evaluation: s[k] <= next, cnt <= period_k.
REQ-027 start_lane[k] with cnt != 0 is a skip: cnt <= cnt-1, and s, changed and the stability count are unaffected.
REQ-028 period_k = 0 SHALL evaluate on every strobe; period_k = 1 SHALL evaluate on every second strobe, starting with the first.
REQ-029 Latency: s reflects the reg_in sampled at the strobe edge one cycle later; changed SHALL assert in that same cycle.
REQ-030 changed[k] SHALL be 1 for exactly the cycle following an evaluation whose next != old s[k], and 0 otherwise.
REQ-031 Stability count per lane: on evaluation, it increments saturating at 2^SW-1 when next == old s, and clears to 0 otherwise.
REQ-032 reset_nos has priority over start_lane in the same cycle: s <= init_state, cnt <= 0, stability count <= 0, changed <= 0.
REQ-033 Lanes SHALL be fully independent; strobes on different lanes in the same cycle are all honoured.
REQ-034 period, func_sel, masks and thr SHALL be sampled at each evaluation; a period change takes effect at the next reload.
REQ-035 Mid-skip changes to period SHALL NOT alter the running cnt.

Reset
REQ-036 While rst is low, asynchronously: s = 0, changed = 0, steady = 0, all cnt = 0, all stability counts = 0.
REQ-037 After rst release, the first start_lane strobe on any lane SHALL be an evaluation.

Verification
REQ-038 N_IN=4, func OR, act_mask=0011, reg_in lane0=0010, period0=0, one strobe -> s[0]=1 next cycle, changed[0] pulses once.
REQ-039 period1=1, 4 strobes on lane1 with reg_in toggling -> s[1] updates only on strobes 1 and 3, using the values sampled at those strobes.
REQ-040 THRESH thr=3, act_mask=1111, reg_in=0111 -> 1; reg_in=0101 -> 0; thr=0 -> 1; thr=5 -> 0.
REQ-041 OR_INH, act_mask=0001, inh_mask=1000, reg_in=1001 -> 0; reg_in=0001 -> 1.
REQ-042 Constant inputs, 8 evaluations on lane0 with STEADY_LIM=8 -> steady[0] rises after the 8th evaluation; one change then clears steady[0] and the count.
REQ-043 reset_nos and start_lane asserted together with init_state=01 -> s=01, no changed pulse; rst low mid-skip -> all outputs 0 immediately, and the next strobe evaluates.

Source files
------------

// File: rtl/gnr_node_lanes.sv
// Multi-lane gene-regulatory node: each lane evaluates a boolean update of its regulators on strobe, with a per-lane strobe divider and stability tracking.
// Latency 1 cycle from an evaluating strobe to s/changed; there is no backpressure, so every strobe is consumed as an evaluation or a skip.
module gnr_node_lanes #(
  parameter int N_IN       = 4,
  parameter int N_LANE     = 2,
  parameter int DIV_W      = 4,
  parameter int SW         = 4,
  parameter int STEADY_LIM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reset_nos,
  input  logic [N_LANE-1:0]                init_state,
  input  logic [N_LANE-1:0]                start_lane,
  input  logic [N_IN*N_LANE-1:0]           reg_in,
  input  logic [N_IN-1:0]                  act_mask,
  input  logic [N_IN-1:0]                  inh_mask,
  input  logic [1:0]                       func_sel,
  input  logic [$clog2(N_IN+1)-1:0]        thr,
  input  logic [DIV_W*N_LANE-1:0]          period,
  output logic [N_LANE-1:0]                s,
  output logic [N_LANE-1:0]                changed,
  output logic [N_LANE-1:0]                steady
);

  localparam int TW = $clog2(N_IN+1);

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    logic [N_IN-1:0]  w_a;
    logic [N_IN-1:0]  w_h;
    logic [TW-1:0]    w_pop;
    logic             w_nxt;
    logic             r_s;
    logic             r_chg;
    logic [DIV_W-1:0] r_cnt;
    logic [SW-1:0]    r_stab;

    assign w_a = reg_in[k*N_IN +: N_IN] & act_mask;
    assign w_h = reg_in[k*N_IN +: N_IN] & inh_mask;

    always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_pop = w_pop + TW'(w_a[i]);
      end
    end

    // Unmasked inputs are forced high for AND, so an empty activator set must be squashed explicitly.
    always_comb begin
      w_nxt = 1'b0;
      case (func_sel)
        2'd0:    w_nxt = |w_a;
        2'd1:    w_nxt = (act_mask != '0) && (&(w_a | ~act_mask));
        2'd2:    w_nxt = (w_pop >= thr);
        default: w_nxt = (|w_a) & ~(|w_h);
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s    <= 1'b0;
        r_chg  <= 1'b0;
        r_cnt  <= '0;
        r_stab <= '0;
      end else if (reset_nos) begin
        r_s    <= init_state[k];
        r_chg  <= 1'b0;
        r_cnt  <= '0;
        r_stab <= '0;
      end else begin
        r_chg <= 1'b0;
        if (start_lane[k]) begin
          if (r_cnt == '0) begin
            r_s   <= w_nxt;
            r_chg <= (w_nxt != r_s);
            r_cnt <= period[k*DIV_W +: DIV_W];
            if (w_nxt == r_s) begin
              if (r_stab != '1) r_stab <= r_stab + 1'b1;
            end else begin
              r_stab <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end

    assign s[k]       = r_s;
    assign changed[k] = r_chg;
    assign steady[k]  = (r_stab >= SW'(STEADY_LIM));
  end

endmodule

// File: tb/tb_gnr_node_lanes.sv
// Bench for gnr_node_lanes: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_gnr_node_lanes;
  logic       clk = 1'b0;
  logic       rst;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [1:0] start_lane;
  logic [7:0] reg_in;
  logic [3:0] act_mask;
  logic [3:0] inh_mask;
  logic [1:0] func_sel;
  logic [2:0] thr;
  logic [7:0] period;
  logic [1:0] s;
  logic [1:0] changed;
  logic [1:0] steady;

  int n_chk = 0;
  int n_err = 0;

  int m_s[2];
  int m_chg[2];
  int m_cnt[2];
  int m_stab[2];

  gnr_node_lanes dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_lane(start_lane), .reg_in(reg_in), .act_mask(act_mask),
    .inh_mask(inh_mask), .func_sel(func_sel), .thr(thr), .period(period),
    .s(s), .changed(changed), .steady(steady)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int k);
    int nact = 0;
    int nmask = 0;
    int anyh = 0;
    logic [3:0] r;
    r = reg_in[k*4 +: 4];
    for (int i = 0; i < 4; i++) begin
      if (act_mask[i]) begin
        nmask++;
        if (r[i]) nact++;
      end
      if (inh_mask[i] && r[i]) anyh = 1;
    end
    case (func_sel)
      2'd0:    return (nact > 0) ? 1 : 0;
      2'd1:    return (nmask > 0 && nact == nmask) ? 1 : 0;
      2'd2:    return (nact >= int'(thr)) ? 1 : 0;
      default: return (nact > 0 && anyh == 0) ? 1 : 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 0; m_chg[k] = 0; m_cnt[k] = 0; m_stab[k] = 0;
    end
  endtask

  task automatic model_clock();
    int nx;
    for (int k = 0; k < 2; k++) begin
      if (reset_nos) begin
        m_s[k] = int'(init_state[k]); m_chg[k] = 0; m_cnt[k] = 0; m_stab[k] = 0;
      end else begin
        m_chg[k] = 0;
        if (start_lane[k]) begin
          if (m_cnt[k] == 0) begin
            nx = model_next(k);
            m_chg[k] = (nx != m_s[k]) ? 1 : 0;
            m_stab[k] = (nx == m_s[k]) ? ((m_stab[k] < 15) ? m_stab[k] + 1 : 15) : 0;
            m_s[k] = nx;
            m_cnt[k] = int'(period[k*4 +: 4]);
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_s();
    return {m_s[1][0], m_s[0][0]};
  endfunction
  function automatic logic [1:0] exp_chg();
    return {m_chg[1][0], m_chg[0][0]};
  endfunction
  function automatic logic [1:0] exp_std();
    return {m_stab[1] >= 8, m_stab[0] >= 8};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic strobe(input logic [1:0] lanes);
    start_lane = lanes;
    step();
    start_lane = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    model_clear();
    n_chk++; if (s !== 2'b00)       begin n_err++; $display("FAIL reset_s got %b want 00", s); end
    n_chk++; if (changed !== 2'b00) begin n_err++; $display("FAIL reset_changed got %b want 00", changed); end
    n_chk++; if (steady !== 2'b00)  begin n_err++; $display("FAIL reset_steady got %b want 00", steady); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_or();
    func_sel = 2'd0; act_mask = 4'b0011; reg_in = 8'h02; period = 8'h00;
    strobe(2'b01);
    n_chk++; if (s[0] !== 1'b1)       begin n_err++; $display("FAIL or_s got %b want 1", s[0]); end
    n_chk++; if (changed[0] !== 1'b1) begin n_err++; $display("FAIL or_chg got %b want 1", changed[0]); end
    step();
    n_chk++; if (changed[0] !== 1'b0) begin n_err++; $display("FAIL or_chg_pulse got %b want 0", changed[0]); end
  endtask

  task automatic test_period();
    logic [3:0] vals [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
    logic       want [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    func_sel = 2'd0; act_mask = 4'b0011; period = 8'h10;
    for (int i = 0; i < 4; i++) begin
      reg_in = {vals[i], 4'b0000};
      strobe(2'b10);
      n_chk++;
      if (s[1] !== want[i]) begin n_err++; $display("FAIL period_strobe%0d got %b want %b", i+1, s[1], want[i]); end
      step();
    end
  endtask

  task automatic test_thresh();
    logic [3:0] regs [4] = '{4'b0111, 4'b0101, 4'b0000, 4'b1111};
    logic [2:0] thrs [4] = '{3'd3, 3'd3, 3'd0, 3'd5};
    logic       want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    func_sel = 2'd2; act_mask = 4'b1111; period = 8'h00;
    for (int i = 0; i < 4; i++) begin
      reg_in = {4'b0000, regs[i]}; thr = thrs[i];
      strobe(2'b01);
      n_chk++;
      if (s[0] !== want[i]) begin n_err++; $display("FAIL thresh_%0d got %b want %b", i, s[0], want[i]); end
    end
  endtask

  task automatic test_and();
    logic [3:0] masks [3] = '{4'b0110, 4'b0110, 4'b0000};
    logic [3:0] regs  [3] = '{4'b0110, 4'b0100, 4'b1111};
    logic       want  [3] = '{1'b1, 1'b0, 1'b0};
    func_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      act_mask = masks[i]; reg_in = {4'b0000, regs[i]};
      strobe(2'b01);
      n_chk++;
      if (s[0] !== want[i]) begin n_err++; $display("FAIL and_%0d got %b want %b", i, s[0], want[i]); end
    end
  endtask

  task automatic test_or_inh();
    func_sel = 2'd3; act_mask = 4'b0001; inh_mask = 4'b1000;
    reg_in = 8'h09;
    strobe(2'b01);
    n_chk++; if (s[0] !== 1'b0) begin n_err++; $display("FAIL orinh_block got %b want 0", s[0]); end
    reg_in = 8'h01;
    strobe(2'b01);
    n_chk++; if (s[0] !== 1'b1) begin n_err++; $display("FAIL orinh_pass got %b want 1", s[0]); end
  endtask

  task automatic test_steady();
    init_state = 2'b01; reset_nos = 1'b1;
    step();
    reset_nos = 1'b0;
    func_sel = 2'd0; act_mask = 4'b0001; reg_in = 8'h01; period = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      strobe(2'b01);
      n_chk++;
      if (steady[0] !== (i >= 8)) begin n_err++; $display("FAIL steady_eval%0d got %b want %b", i, steady[0], (i >= 8)); end
    end
    reg_in = 8'h00;
    strobe(2'b01);
    n_chk++; if (steady[0] !== 1'b0 || changed[0] !== 1'b1)
      begin n_err++; $display("FAIL steady_clear got steady=%b chg=%b want steady=0 chg=1", steady[0], changed[0]); end
    for (int i = 1; i <= 8; i++) begin
      strobe(2'b01);
      n_chk++;
      if (steady[0] !== (i >= 8)) begin n_err++; $display("FAIL steady_recount%0d got %b want %b", i, steady[0], (i >= 8)); end
    end
  endtask

  task automatic test_nos();
    init_state = 2'b01; reset_nos = 1'b1; reg_in = 8'hFF; act_mask = 4'b1111; func_sel = 2'd0;
    strobe(2'b11);
    reset_nos = 1'b0;
    n_chk++; if (s !== 2'b01 || changed !== 2'b00)
      begin n_err++; $display("FAIL nos_prio got s=%b chg=%b want s=01 chg=00", s, changed); end
  endtask

  task automatic test_async();
    func_sel = 2'd0; act_mask = 4'b1111; reg_in = 8'h10; period = 8'h30;
    strobe(2'b10);
    strobe(2'b10);
    #3 rst = 1'b0;
    #1;
    model_clear();
    n_chk++; if ({s, changed, steady} !== 6'b0)
      begin n_err++; $display("FAIL async_rst got s=%b chg=%b std=%b want all 0", s, changed, steady); end
    #2 rst = 1'b1;
    strobe(2'b10);
    n_chk++; if (s[1] !== 1'b1 || changed[1] !== 1'b1)
      begin n_err++; $display("FAIL async_first_eval got s1=%b chg1=%b want 1 1", s[1], changed[1]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_nos  = ($urandom_range(0, 31) == 0);
      init_state = 2'($urandom);
      start_lane = 2'($urandom);
      reg_in     = 8'($urandom);
      act_mask   = 4'($urandom);
      inh_mask   = 4'($urandom);
      func_sel   = 2'($urandom);
      thr        = 3'($urandom_range(0, 5));
      period     = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 2))};
      step();
      n_chk++;
      if (s !== exp_s() || changed !== exp_chg() || steady !== exp_std()) begin
        n_err++;
        $display("FAIL random_%0d got s=%b chg=%b std=%b want s=%b chg=%b std=%b",
                 i, s, changed, steady, exp_s(), exp_chg(), exp_std());
      end
    end
    reset_nos = 1'b0; start_lane = 2'b00;
  endtask

  initial begin
    rst = 1'b0; reset_nos = 1'b0; init_state = 2'b00; start_lane = 2'b00;
    reg_in = 8'h00; act_mask = 4'h0; inh_mask = 4'h0; func_sel = 2'd0;
    thr = 3'd0; period = 8'h00;
    model_clear();
    test_reset();
    test_or();
    test_period();
    test_thresh();
    test_and();
    test_or_inh();
    test_steady();
    test_nos();
    test_async();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
